// File: rtl/vga_pkg.sv
// Shared coordinate type and default 800x600@72Hz timing constants for the VGA timing generator.
// Pure declarations: no logic, no latency, no backpressure.
package vga_pkg;

    typedef logic [11:0] coord_t;

    localparam int   H_SIZE = 800;
    localparam int   H_FP   = 856;
    localparam int   H_SP   = 976;
    localparam int   H_MAX  = 1040;
    localparam int   V_SIZE = 600;
    localparam int   V_FP   = 637;
    localparam int   V_SP   = 643;
    localparam int   V_MAX  = 666;
    localparam logic H_POL  = 1'b1;
    localparam logic V_POL  = 1'b1;

    // Half-open window test used for both sync pulses: lo <= v < hi.
    function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_timing_wrap_counter.sv
// Enabled 12-bit counter that wraps from MAX-1 to 0; o_wrap flags the enabled wrap cycle.
// Count is registered, o_wrap is combinational from it; free-running, no backpressure.
module wrap_counter
    import vga_pkg::*;
#(
    parameter int MAX = H_MAX
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   i_en,
    output coord_t o_count,
    output logic   o_wrap
);

    coord_t r_count;
    logic   w_last;

    assign w_last  = (r_count == coord_t'(MAX - 1));
    assign o_wrap  = i_en && w_last;
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_last ? '0 : r_count + coord_t'(1);
        end
    end

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing: pixel/line counters with sync, data-enable and frame-start decode; optional VGA_FRAME_CNT_EN frame counter.
// Decodes have zero latency w.r.t. hdata/vdata; free-running at the pixel clock, no backpressure.
module vga_timing
    import vga_pkg::*;
#(
    parameter int   HSIZE = H_SIZE,
    parameter int   HFP   = H_FP,
    parameter int   HSP   = H_SP,
    parameter int   HMAX  = H_MAX,
    parameter int   VSIZE = V_SIZE,
    parameter int   VFP   = V_FP,
    parameter int   VSP   = V_SP,
    parameter int   VMAX  = V_MAX,
    parameter logic HSPP  = H_POL,
    parameter logic VSPP  = V_POL
) (
    input  logic        clk,
    input  logic        reset,
    output logic [11:0] hdata,
    output logic [11:0] vdata,
    output logic        hsync,
    output logic        vsync,
    output logic        data_enable,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    coord_t w_hcount;
    coord_t w_vcount;
    logic   w_hwrap;
    logic   w_vwrap;

    wrap_counter #(.MAX(HMAX)) u_hcnt (
        .clk     (clk),
        .reset   (reset),
        .i_en    (1'b1),
        .o_count (w_hcount),
        .o_wrap  (w_hwrap)
    );

    // Line counter only advances on the pixel counter's wrap, so its wrap marks the end of a frame.
    wrap_counter #(.MAX(VMAX)) u_vcnt (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_hwrap),
        .o_count (w_vcount),
        .o_wrap  (w_vwrap)
    );

    assign hdata = w_hcount;
    assign vdata = w_vcount;

    // Reset gates the decodes directly so they sit at their idle levels for every reset cycle.
    assign hsync       = (!reset && in_window(w_hcount, coord_t'(HFP), coord_t'(HSP))) ? HSPP : ~HSPP;
    assign vsync       = (!reset && in_window(w_vcount, coord_t'(VFP), coord_t'(VSP))) ? VSPP : ~VSPP;
    assign data_enable = !reset && (w_hcount < coord_t'(HSIZE)) && (w_vcount < coord_t'(VSIZE));
    assign frame_start = !reset && (w_hcount == '0) && (w_vcount == '0);

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt <= '0;
        end else if (w_vwrap) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing: a default instance for horizontal timing and a short-frame instance for vertical/frame behaviour.
module tb_vga_timing;
    localparam int F_H = 0, F_V = 1, F_HS = 2, F_VS = 3, F_DE = 4, F_FS = 5, F_FC = 6, F_FSCNT = 7;
    localparam int I_D = 0, I_S = 1;

`ifdef VGA_FRAME_CNT_EN
    localparam logic [15:0] FC1 = 16'd1;
    localparam logic [15:0] FC2 = 16'd2;
`else
    localparam logic [15:0] FC1 = 16'd0;
    localparam logic [15:0] FC2 = 16'd0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] hd_d, vd_d, hd_s, vd_s;
    logic        hs_d, vs_d, de_d, fs_d, hs_s, vs_s, de_s, fs_s;
    logic [15:0] fc_d, fc_s;

    always #5 clk = ~clk;

    vga_timing dut_d (
        .clk (clk), .reset (reset), .hdata (hd_d), .vdata (vd_d), .hsync (hs_d), .vsync (vs_d),
        .data_enable (de_d), .frame_start (fs_d), .frame_cnt (fc_d)
    );

    // Same horizontal timing, 12-line frame: 12480 cycles per frame.
    vga_timing #(.VSIZE(6), .VFP(7), .VSP(9), .VMAX(12)) dut_s (
        .clk (clk), .reset (reset), .hdata (hd_s), .vdata (vd_s), .hsync (hs_s), .vsync (vs_s),
        .data_enable (de_s), .frame_start (fs_s), .frame_cnt (fc_s)
    );

    typedef struct {
        int          inst;
        int          fld;
        logic [15:0] val;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   fs_cnt_s = 0;
    int   t;

    function automatic logic [15:0] actual(int inst, int fld);
        logic [15:0] a;
        a = 'x;
        if (inst == I_D) begin
            case (fld)
                F_H:  a = {4'd0, hd_d};
                F_V:  a = {4'd0, vd_d};
                F_HS: a = {15'd0, hs_d};
                F_VS: a = {15'd0, vs_d};
                F_DE: a = {15'd0, de_d};
                F_FS: a = {15'd0, fs_d};
                F_FC: a = fc_d;
                default: a = 'x;
            endcase
        end else begin
            case (fld)
                F_H:     a = {4'd0, hd_s};
                F_V:     a = {4'd0, vd_s};
                F_HS:    a = {15'd0, hs_s};
                F_VS:    a = {15'd0, vs_s};
                F_DE:    a = {15'd0, de_s};
                F_FS:    a = {15'd0, fs_s};
                F_FC:    a = fc_s;
                F_FSCNT: a = 16'(fs_cnt_s);
                default: a = 'x;
            endcase
        end
        return a;
    endfunction

    // Monitor: counts frame_start pulses and retires every expectation queued for this cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] a;
        if (fs_s === 1'b1) fs_cnt_s++;
        while (q.size() > 0) begin
            e = q.pop_front();
            a = actual(e.inst, e.fld);
            n_cmp++;
            if (a !== e.val) begin
                n_err++;
                $display("FAIL %s (inst %0d): got %0d expected %0d", e.nm, e.inst, a, e.val);
            end
        end
    end

    task automatic chk(input int inst, input int fld, input logic [15:0] val, input string nm);
        exp_t e;
        e.inst = inst;
        e.fld  = fld;
        e.val  = val;
        e.nm   = nm;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic go(input int target);
        while (t < target) tick();
    endtask

    task automatic chk_reset(input int inst, input string nm);
        chk(inst, F_H,  16'd0, {nm, "_h"});
        chk(inst, F_V,  16'd0, {nm, "_v"});
        chk(inst, F_HS, 16'd0, {nm, "_hs"});
        chk(inst, F_VS, 16'd0, {nm, "_vs"});
        chk(inst, F_DE, 16'd0, {nm, "_de"});
        chk(inst, F_FS, 16'd0, {nm, "_fs"});
        chk(inst, F_FC, 16'd0, {nm, "_fc"});
    endtask

    initial begin
        reset = 1'b1;
        t = -100;
        repeat (3) tick();
        chk_reset(I_D, "rst");
        chk_reset(I_S, "rst");
        tick();
        reset = 1'b0;
        t = 0;
        chk(I_D, F_H, 16'd0, "rel_h");
        chk(I_D, F_V, 16'd0, "rel_v");
        chk(I_D, F_FS, 16'd1, "rel_fs");
        chk(I_D, F_DE, 16'd1, "rel_de");
        chk(I_S, F_FS, 16'd1, "rel_fs_s");
        go(1);
        chk(I_D, F_H, 16'd1, "rel1_h");
        chk(I_D, F_FS, 16'd0, "rel1_fs");

        go(799);  chk(I_D, F_DE, 16'd1, "de_799_0");
        go(800);  chk(I_D, F_DE, 16'd0, "de_800_0");
                  chk(I_D, F_HS, 16'd0, "hs_800");
        go(855);  chk(I_D, F_HS, 16'd0, "hs_855");
        for (int h = 856; h <= 975; h++) begin
            go(h);
            chk(I_D, F_HS, 16'd1, "hs_active");
        end
        go(976);  chk(I_D, F_HS, 16'd0, "hs_976");
        go(1039); chk(I_D, F_H, 16'd1039, "hwrap_pre_h");
                  chk(I_D, F_V, 16'd0, "hwrap_pre_v");
        go(1040); chk(I_D, F_H, 16'd0, "hwrap_h");
                  chk(I_D, F_V, 16'd1, "hwrap_v");
                  chk(I_D, F_DE, 16'd1, "de_0_1");

        go(5 * 1040 + 799);
        chk(I_S, F_H, 16'd799, "last_vis_h");
        chk(I_S, F_V, 16'd5, "last_vis_v");
        chk(I_S, F_DE, 16'd1, "de_last_vis");
        go(6 * 1040);
        chk(I_S, F_DE, 16'd0, "de_0_vsize");
        chk(I_S, F_VS, 16'd0, "vs_line6");
        chk(I_D, F_DE, 16'd1, "de_0_6_d");
        go(7 * 1040);        chk(I_S, F_VS, 16'd1, "vs_line7");
        go(8 * 1040 + 1039); chk(I_S, F_VS, 16'd1, "vs_line8_end");
        go(9 * 1040);        chk(I_S, F_VS, 16'd0, "vs_line9");
                             chk(I_D, F_VS, 16'd0, "vs_line9_d");

        go(12479);
        chk(I_S, F_H, 16'd1039, "fwrap_pre_h");
        chk(I_S, F_V, 16'd11, "fwrap_pre_v");
        chk(I_S, F_FC, 16'd0, "fwrap_pre_fc");
        go(12480);
        chk(I_S, F_H, 16'd0, "fwrap_h");
        chk(I_S, F_V, 16'd0, "fwrap_v");
        chk(I_S, F_FS, 16'd1, "fwrap_fs");
        chk(I_S, F_FC, FC1, "fwrap_fc1");
        go(12481);
        chk(I_S, F_FS, 16'd0, "fwrap_fs_off");
        go(24959);
        chk(I_S, F_FSCNT, 16'd2, "fs_pulses_2f");
        go(24960);
        chk(I_S, F_FS, 16'd1, "f2_fs");
        chk(I_S, F_FC, FC2, "f2_fc");
        chk(I_D, F_FC, 16'd0, "f2_fc_d");
        chk(I_D, F_H, 16'd0, "f2_h_d");
        chk(I_D, F_V, 16'd24, "f2_v_d");

        go(24960 + 3 * 1040 + 500);
        chk(I_S, F_H, 16'd500, "mid_h");
        chk(I_S, F_V, 16'd3, "mid_v");
        chk(I_S, F_DE, 16'd1, "mid_de");
        @(negedge clk);
        #1;
        reset = 1'b1;
        tick();
        chk_reset(I_S, "midrst");
        chk_reset(I_D, "midrst");
        tick();
        reset = 1'b0;
        t = 0;
        chk(I_S, F_H, 16'd0, "rerel_h");
        chk(I_S, F_V, 16'd0, "rerel_v");
        chk(I_S, F_FS, 16'd1, "rerel_fs");
        chk(I_S, F_FC, 16'd0, "rerel_fc");
        chk(I_D, F_V, 16'd0, "rerel_v_d");
        go(1);
        chk(I_S, F_H, 16'd1, "rerel1_h");
        chk(I_S, F_FS, 16'd0, "rerel1_fs");

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
